// File: rtl/move_sequencer.sv
// Move sequencer: walks the four rows/columns of a move through a shared
// line-merge unit, spawns a tile if anything changed, and keeps a count of
// effective moves. One move press may be queued while the sequencer is busy.
//
// state | meaning
// IDLE  | waiting for a move or manual spawn
// LINE  | line_req high; merging line line_idx in direction line_dir
// SPAWN | spawn_req high; waiting for the spawner
// DONE  | one-cycle move_done; start queued move or return to IDLE
module move_sequencer (
    input  logic       clk_d,
    input  logic       rst,
    input  logic       start_sw,
    input  logic [3:0] act_flag,
    input  logic       random_flag,
    output logic       line_req,
    output logic [1:0] line_dir,
    output logic [1:0] line_idx,
    input  logic       line_ack,
    input  logic       line_changed,
    output logic       spawn_req,
    input  logic       spawn_ack,
    output logic       busy,
    output logic       move_done,
    output logic [7:0] move_cnt
);

    typedef enum logic [1:0] {IDLE, LINE, SPAWN, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] idx_q, idx_d;
    logic       acc_q, acc_d;
    logic       is_move_q, is_move_d;
    logic       pend_vld_q, pend_vld_d;
    logic [1:0] pend_dir_q, pend_dir_d;
    logic [7:0] cnt_q, cnt_d;

    logic       act_any;
    logic [1:0] act_dir;
    logic       acc_next;

    // Fixed-priority pick of one direction from the move pulses (bit0 wins)
    always_comb begin
        act_any = |act_flag;
        act_dir = 2'd0;
        if (act_flag[0])      act_dir = 2'd0;
        else if (act_flag[1]) act_dir = 2'd1;
        else if (act_flag[2]) act_dir = 2'd2;
        else if (act_flag[3]) act_dir = 2'd3;
    end

    // Next-state, datapath and pending-queue logic
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        is_move_d  = is_move_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        cnt_d      = cnt_q;
        acc_next   = acc_q | line_changed;

        if (!start_sw) begin
            // Game mode off: abandon everything except the move count
            state_d    = IDLE;
            pend_vld_d = 1'b0;
            acc_d      = 1'b0;
        end else begin
            // Queue one press while busy; later presses are dropped
            if (state_q != IDLE && !pend_vld_q && act_any) begin
                pend_vld_d = 1'b1;
                pend_dir_d = act_dir;
            end

            unique case (state_q)
                IDLE: begin
                    if (act_any) begin
                        state_d   = LINE;
                        dir_d     = act_dir;
                        idx_d     = 2'd0;
                        acc_d     = 1'b0;
                        is_move_d = 1'b1;
                    end else if (random_flag) begin
                        state_d   = SPAWN;
                        acc_d     = 1'b0;
                        is_move_d = 1'b0;
                    end
                end
                LINE: begin
                    if (line_ack) begin
                        acc_d = acc_next;
                        if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
                        else               state_d = acc_next ? SPAWN : DONE;
                    end
                end
                SPAWN: begin
                    if (spawn_ack) state_d = DONE;
                end
                DONE: begin
                    if (is_move_q && acc_q) cnt_d = cnt_q + 8'd1;
                    // A press arriving in DONE itself starts directly rather
                    // than being parked in the queue across IDLE
                    pend_vld_d = 1'b0;
                    if (pend_vld_q || act_any) begin
                        state_d   = LINE;
                        dir_d     = pend_vld_q ? pend_dir_q : act_dir;
                        idx_d     = 2'd0;
                        acc_d     = 1'b0;
                        is_move_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers, cleared asynchronously by rst
    always_ff @(posedge clk_d or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dir_q      <= 2'd0;
            idx_q      <= 2'd0;
            acc_q      <= 1'b0;
            is_move_q  <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dir_q <= 2'd0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            is_move_q  <= is_move_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs decoded from state; move_done is muted when game mode drops
    always_comb begin
        line_req  = (state_q == LINE);
        spawn_req = (state_q == SPAWN);
        busy      = (state_q != IDLE);
        move_done = (state_q == DONE) && start_sw;
        line_dir  = dir_q;
        line_idx  = idx_q;
        move_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: one task per scenario, inline checks.
module tb_move_sequencer;

    logic       clk_d = 1'b0;
    logic       rst;
    logic       start_sw;
    logic [3:0] act_flag;
    logic       random_flag;
    logic       line_req;
    logic [1:0] line_dir;
    logic [1:0] line_idx;
    logic       line_ack;
    logic       line_changed;
    logic       spawn_req;
    logic       spawn_ack;
    logic       busy;
    logic       move_done;
    logic [7:0] move_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_cnt;

    // statistics gathered by run_seq
    int n_line, n_spawn, n_done, done_k1, done_k2, idx_err, idx_unstable;
    logic [1:0] dir_k1, dir_2;
    logic lreq_k1, busy_end, probe_req, probe_busy;

    move_sequencer dut (
        .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .act_flag(act_flag),
        .random_flag(random_flag), .line_req(line_req), .line_dir(line_dir),
        .line_idx(line_idx), .line_ack(line_ack), .line_changed(line_changed),
        .spawn_req(spawn_req), .spawn_ack(spawn_ack), .busy(busy),
        .move_done(move_done), .move_cnt(move_cnt)
    );

    always #5 clk_d = ~clk_d;

    // Drive one press at cycle 0, then play merge unit / spawner for ncyc cycles.
    // k counts cycles after the press cycle; outputs sampled on falling edges.
    task automatic run_seq(input logic [3:0] a, input logic rnd, input logic [3:0] chg,
                           input int dly, input logic [3:0] p2, input int k2,
                           input logic [3:0] p3, input int k3, input int drop_k,
                           input int ncyc);
        int w, acks;
        logic prev_req, prev_ack;
        logic [1:0] prev_idx;
        n_line = 0; n_spawn = 0; n_done = 0; done_k1 = -1; done_k2 = -1;
        idx_err = 0; idx_unstable = 0; dir_k1 = 2'd0; dir_2 = 2'd0;
        lreq_k1 = 1'b0; probe_req = 1'b1; probe_busy = 1'b1;
        w = 0; acks = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_idx = 2'd0;
        @(negedge clk_d);
        act_flag = a; random_flag = rnd; line_ack = 1'b0; spawn_ack = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk_d);
            if (k == 1) begin lreq_k1 = line_req; dir_k1 = line_dir; end
            if (k == drop_k + 1) begin probe_req = line_req | spawn_req; probe_busy = busy; end
            if (line_req) n_line++;
            if (spawn_req) n_spawn++;
            if (move_done) begin
                n_done++;
                if (n_done == 1) done_k1 = k;
                else if (n_done == 2) done_k2 = k;
            end
            if (line_req && n_done == 1 && k == done_k1 + 1) dir_2 = line_dir;
            if (line_req && prev_req && !prev_ack && line_idx != prev_idx) idx_unstable++;
            act_flag = (k == k2) ? p2 : (k == k3) ? p3 : 4'd0;
            random_flag = 1'b0;
            if (k == drop_k) start_sw = 1'b0;
            if (line_req) begin
                if (w == dly) begin
                    line_ack = 1'b1; w = 0;
                    if (line_idx != acks[1:0]) idx_err++;
                    acks++;
                end else begin
                    line_ack = 1'b0; w++;
                end
            end else begin
                line_ack = 1'b0;
            end
            line_changed = line_ack && chg[line_idx];
            spawn_ack = spawn_req;
            prev_req = line_req; prev_ack = line_ack; prev_idx = line_idx;
        end
        busy_end = busy;
        act_flag = 4'd0; random_flag = 1'b0; line_ack = 1'b0;
        line_changed = 1'b0; spawn_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start_sw = 1'b0; act_flag = 4'd0; random_flag = 1'b0;
        line_ack = 1'b0; line_changed = 1'b0; spawn_ack = 1'b0;
        repeat (3) @(negedge clk_d);
        if ({line_req, spawn_req, busy, move_done, line_dir, line_idx, move_cnt} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b sreq=%b busy=%b done=%b dir=%0d idx=%0d cnt=%0d want all 0",
                     line_req, spawn_req, busy, move_done, line_dir, line_idx, move_cnt);
        end
        n_cmp++;
        rst = 1'b1; start_sw = 1'b1; exp_cnt = 8'd0;
        @(negedge clk_d);
    endtask

    task automatic test_left_changed();
        run_seq(4'b0100, 1'b0, 4'b0100, 0, 4'd0, -1, 4'd0, -1, -1, 8);
        exp_cnt = exp_cnt + 8'd1;
        if (lreq_k1 !== 1'b1) begin n_fail++; $display("FAIL left_req_n1 got %b want 1", lreq_k1); end
        n_cmp++;
        if (dir_k1 !== 2'd2) begin n_fail++; $display("FAIL left_dir got %0d want 2", dir_k1); end
        n_cmp++;
        if (n_line != 4 || idx_err != 0) begin n_fail++; $display("FAIL left_lines got n=%0d idxerr=%0d want 4/0", n_line, idx_err); end
        n_cmp++;
        if (n_spawn != 1) begin n_fail++; $display("FAIL left_spawn got %0d want 1", n_spawn); end
        n_cmp++;
        if (done_k1 != 6 || n_done != 1) begin n_fail++; $display("FAIL left_done_at got k=%0d n=%0d want 6/1", done_k1, n_done); end
        n_cmp++;
        if (move_cnt !== exp_cnt) begin n_fail++; $display("FAIL left_cnt got %0d want %0d", move_cnt, exp_cnt); end
        n_cmp++;
    endtask

    task automatic test_up_unchanged();
        run_seq(4'b0001, 1'b0, 4'b0000, 0, 4'd0, -1, 4'd0, -1, -1, 7);
        if (dir_k1 !== 2'd0) begin n_fail++; $display("FAIL up_dir got %0d want 0", dir_k1); end
        n_cmp++;
        if (n_spawn != 0) begin n_fail++; $display("FAIL up_spawn got %0d want 0", n_spawn); end
        n_cmp++;
        if (done_k1 != 5) begin n_fail++; $display("FAIL up_done_at got %0d want 5", done_k1); end
        n_cmp++;
        if (move_cnt !== exp_cnt) begin n_fail++; $display("FAIL up_cnt got %0d want %0d", move_cnt, exp_cnt); end
        n_cmp++;
    endtask

    task automatic test_spawn_only();
        run_seq(4'b0000, 1'b1, 4'b0000, 0, 4'd0, -1, 4'd0, -1, -1, 4);
        if (n_spawn != 1 || n_line != 0 || done_k1 != 2) begin
            n_fail++; $display("FAIL spawn_only got spawn=%0d line=%0d done=%0d want 1/0/2", n_spawn, n_line, done_k1);
        end
        n_cmp++;
        if (move_cnt !== exp_cnt) begin n_fail++; $display("FAIL spawn_only_cnt got %0d want %0d", move_cnt, exp_cnt); end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        run_seq(4'b1010, 1'b1, 4'b0000, 0, 4'b1000, 2, 4'b0001, 3, -1, 12);
        if (dir_k1 !== 2'd1) begin n_fail++; $display("FAIL b2b_dir1 got %0d want 1", dir_k1); end
        n_cmp++;
        if (n_spawn != 0) begin n_fail++; $display("FAIL b2b_spawn got %0d want 0", n_spawn); end
        n_cmp++;
        if (done_k1 != 5 || done_k2 != 10 || n_done != 2) begin
            n_fail++; $display("FAIL b2b_done got k1=%0d k2=%0d n=%0d want 5/10/2", done_k1, done_k2, n_done);
        end
        n_cmp++;
        if (dir_2 !== 2'd3) begin n_fail++; $display("FAIL b2b_dir2 got %0d want 3", dir_2); end
        n_cmp++;
        if (busy_end !== 1'b0 || n_line != 8) begin
            n_fail++; $display("FAIL b2b_third_drop got busy=%b lines=%0d want 0/8", busy_end, n_line);
        end
        n_cmp++;
    endtask

    task automatic test_slow_ack();
        run_seq(4'b0010, 1'b0, 4'b0000, 3, 4'd0, -1, 4'd0, -1, -1, 19);
        if (n_line != 16 || idx_err != 0 || idx_unstable != 0) begin
            n_fail++; $display("FAIL slow_lines got n=%0d idxerr=%0d unstable=%0d want 16/0/0", n_line, idx_err, idx_unstable);
        end
        n_cmp++;
        if (done_k1 != 17) begin n_fail++; $display("FAIL slow_done_at got %0d want 17", done_k1); end
        n_cmp++;
    endtask

    task automatic test_start_drop();
        run_seq(4'b0100, 1'b0, 4'b1111, 0, 4'd0, -1, 4'd0, -1, 2, 8);
        if (probe_req !== 1'b0 || probe_busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle got req=%b busy=%b want 0/0", probe_req, probe_busy);
        end
        n_cmp++;
        if (n_done != 0 || n_line != 2) begin n_fail++; $display("FAIL drop_done got done=%0d lines=%0d want 0/2", n_done, n_line); end
        n_cmp++;
        if (move_cnt !== exp_cnt) begin n_fail++; $display("FAIL drop_cnt got %0d want %0d", move_cnt, exp_cnt); end
        n_cmp++;
        start_sw = 1'b1;
        @(negedge clk_d);
    endtask

    task automatic test_async_reset();
        logic seen;
        seen = 1'b0;
        @(negedge clk_d);
        act_flag = 4'b0100;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_d);
            act_flag = 4'd0;
            if (spawn_req) seen = 1'b1;
            line_ack = line_req; line_changed = line_req; spawn_ack = 1'b0;
        end
        line_ack = 1'b0; line_changed = 1'b0;
        if (!seen) begin n_fail++; $display("FAIL areset_reach_spawn got timeout want spawn_req"); end
        n_cmp++;
        #2 rst = 1'b0;
        #1;
        if ({line_req, spawn_req, busy, move_done, line_dir, line_idx, move_cnt} !== 15'd0) begin
            n_fail++;
            $display("FAIL areset_outputs got req=%b sreq=%b busy=%b dir=%0d idx=%0d cnt=%0d want all 0",
                     line_req, spawn_req, busy, line_dir, line_idx, move_cnt);
        end
        n_cmp++;
        exp_cnt = 8'd0;
        @(negedge clk_d);
        rst = 1'b1;
        act_flag = 4'b0010;
        @(negedge clk_d);
        act_flag = 4'd0;
        if (line_req !== 1'b1 || line_dir !== 2'd1) begin
            n_fail++; $display("FAIL post_reset_act got req=%b dir=%0d want 1/1", line_req, line_dir);
        end
        n_cmp++;
        start_sw = 1'b0;
        @(negedge clk_d);
        start_sw = 1'b1;
        @(negedge clk_d);
    endtask

    task automatic test_wrap();
        for (int m = 0; m < 256; m++) begin
            run_seq(4'b1000, 1'b0, 4'b1111, 0, 4'd0, -1, 4'd0, -1, -1, 7);
            exp_cnt = exp_cnt + 8'd1;
            if (m == 254) begin
                if (move_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d want 255", move_cnt); end
                n_cmp++;
            end
        end
        if (move_cnt !== 8'd0 || exp_cnt !== 8'd0) begin
            n_fail++; $display("FAIL wrap_0 got %0d want 0", move_cnt);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_left_changed();
        test_up_unchanged();
        test_spawn_only();
        test_back_to_back();
        test_slow_ack();
        test_start_drop();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
